// File: rtl/oled_bus_responder.sv
// ---------------------------------------------------------------------------
// oled_bus_responder
//   Responder end of a 6800-style OLED parallel bus. It decodes the
//   command/argument byte stream, reports each complete command as a
//   one-cycle event, tracks the column/row address window, and turns
//   RAM-write (0x5C) pixel data into framebuffer writes.
//
// Ports
//   clk, rst          system clock, asynchronous active-high reset
//   oled_cs           chip select, active low
//   oled_e            enable strobe; byte taken on its falling edge
//   oled_rw           0 = write, 1 = read (reads are ignored)
//   oled_dc           0 = command byte, 1 = data byte
//   oled_din[7:0]     bus data
//   cmd_valid         one-cycle pulse, command complete
//   cmd, arg0, arg1   opcode and arguments of the last reported command
//   fb_we             one-cycle framebuffer write strobe
//   fb_addr           row*WIDTH + col
//   fb_din            RGB565 pixel (high byte arrives first)
//   display_on        set by 0xAF, cleared by 0xAE
//   err               one-cycle protocol-error pulse
//
// Bus handshake: a byte is accepted in the cycle where the registered
// enable is 1, the live enable is 0, cs is low and rw is low. Every response
// is registered and appears one cycle after that strobe cycle.
//
// Build option
//   OLED_RX_SYNC_EN  : pass all bus inputs through a 2-flop synchronizer
//                      before edge detection (adds 2 cycles of latency).
// ---------------------------------------------------------------------------
module oled_bus_responder #(
  parameter int WIDTH  = 128,
  parameter int HEIGHT = 128,
  parameter int FB_AW  = 14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             oled_cs,
  input  logic             oled_e,
  input  logic             oled_rw,
  input  logic             oled_dc,
  input  logic [7:0]       oled_din,
  output logic             cmd_valid,
  output logic [7:0]       cmd,
  output logic [7:0]       arg0,
  output logic [7:0]       arg1,
  output logic             fb_we,
  output logic [FB_AW-1:0] fb_addr,
  output logic [15:0]      fb_din,
  output logic             display_on,
  output logic             err
);

  localparam int CW = $clog2(WIDTH);
  localparam int RW = $clog2(HEIGHT);

  typedef enum logic [1:0] {S_CMD, S_ARGS, S_PIX_HI, S_PIX_LO} state_t;

  // Bus as seen by the edge detector
  logic       b_cs, b_e, b_rw, b_dc;
  logic [7:0] b_din;

`ifdef OLED_RX_SYNC_EN
  logic [11:0] sync1_d, sync1_q, sync2_q;
  assign sync1_d = {oled_cs, oled_e, oled_rw, oled_dc, oled_din};
  // cs resets high so the bus looks deselected until real samples arrive
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 12'h800;
      sync2_q <= 12'h800;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync1_q;
    end
  end
  assign {b_cs, b_e, b_rw, b_dc, b_din} = sync2_q;
`else
  assign {b_cs, b_e, b_rw, b_dc, b_din} = {oled_cs, oled_e, oled_rw, oled_dc, oled_din};
`endif

  function automatic logic [1:0] arity(input logic [7:0] op);
    case (op)
      8'h15, 8'h75, 8'hA0, 8'hB4, 8'hD1: arity = 2'd2;
      8'hAE, 8'hAF, 8'h5C:               arity = 2'd0;
      default:                           arity = 2'd1;
    endcase
  endfunction

  function automatic logic [CW-1:0] clamp_col(input logic [7:0] v);
    if (int'(v) > WIDTH - 1) clamp_col = CW'(WIDTH - 1);
    else                     clamp_col = CW'(v);
  endfunction

  function automatic logic [RW-1:0] clamp_row(input logic [7:0] v);
    if (int'(v) > HEIGHT - 1) clamp_row = RW'(HEIGHT - 1);
    else                      clamp_row = RW'(v);
  endfunction

  state_t           state_q, state_d;
  logic             e_q;
  logic [7:0]       opc_q, opc_d, a0_q, a0_d, hi_q, hi_d;
  logic [1:0]       rem_q, rem_d;
  logic [CW-1:0]    col_start_q, col_start_d, col_end_q, col_end_d, col_q, col_d;
  logic [RW-1:0]    row_start_q, row_start_d, row_end_q, row_end_d, row_q, row_d;
  logic             cmd_valid_q, cmd_valid_d, fb_we_q, fb_we_d, err_q, err_d;
  logic             display_on_q, display_on_d;
  logic [7:0]       cmd_q, cmd_d, arg0_q, arg0_d, arg1_q, arg1_d;
  logic [FB_AW-1:0] fb_addr_q, fb_addr_d;
  logic [15:0]      fb_din_q, fb_din_d;
  logic             strobe;
  logic [CW-1:0]    win_c_lo, win_c_hi;
  logic [RW-1:0]    win_r_lo, win_r_hi;

  assign strobe = e_q && !b_e && !b_cs && !b_rw;

  always_comb begin
    state_d      = state_q;
    opc_d        = opc_q;
    a0_d         = a0_q;
    hi_d         = hi_q;
    rem_d        = rem_q;
    col_start_d  = col_start_q;
    col_end_d    = col_end_q;
    row_start_d  = row_start_q;
    row_end_d    = row_end_q;
    col_d        = col_q;
    row_d        = row_q;
    cmd_valid_d  = 1'b0;
    fb_we_d      = 1'b0;
    err_d        = 1'b0;
    display_on_d = display_on_q;
    cmd_d        = cmd_q;
    arg0_d       = arg0_q;
    arg1_d       = arg1_q;
    fb_addr_d    = fb_addr_q;
    fb_din_d     = fb_din_q;

    // Window bounds for a completing 0x15/0x75: first arg is in a0_q,
    // second arg is on the bus. The end never precedes the start.
    win_c_lo = clamp_col(a0_q);
    win_c_hi = (clamp_col(b_din) < win_c_lo) ? win_c_lo : clamp_col(b_din);
    win_r_lo = clamp_row(a0_q);
    win_r_hi = (clamp_row(b_din) < win_r_lo) ? win_r_lo : clamp_row(b_din);

    if (strobe && !b_dc) begin
      // A command byte always starts a fresh command; a half-finished
      // argument list or pixel is an error, leaving RAM-write mode is not.
      if (state_q == S_ARGS || state_q == S_PIX_LO) err_d = 1'b1;
      if (arity(b_din) == 2'd0) begin
        cmd_valid_d = 1'b1;
        cmd_d       = b_din;
        arg0_d      = 8'h00;
        arg1_d      = 8'h00;
        state_d     = S_CMD;
        if (b_din == 8'hAF) display_on_d = 1'b1;
        if (b_din == 8'hAE) display_on_d = 1'b0;
        if (b_din == 8'h5C) begin
          col_d   = col_start_q;
          row_d   = row_start_q;
          state_d = S_PIX_HI;
        end
      end else begin
        opc_d   = b_din;
        rem_d   = arity(b_din);
        state_d = S_ARGS;
      end
    end else if (strobe && b_dc) begin
      case (state_q)
        S_CMD: err_d = 1'b1;
        S_ARGS: begin
          rem_d = rem_q - 2'd1;
          if (rem_q == arity(opc_q)) a0_d = b_din;
          if (rem_q == 2'd1) begin
            cmd_valid_d = 1'b1;
            cmd_d       = opc_q;
            state_d     = S_CMD;
            if (arity(opc_q) == 2'd2) begin
              arg0_d = a0_q;
              arg1_d = b_din;
            end else begin
              arg0_d = b_din;
              arg1_d = 8'h00;
            end
            if (opc_q == 8'h15) begin
              col_start_d = win_c_lo;
              col_end_d   = win_c_hi;
            end
            if (opc_q == 8'h75) begin
              row_start_d = win_r_lo;
              row_end_d   = win_r_hi;
            end
          end
        end
        S_PIX_HI: begin
          hi_d    = b_din;
          state_d = S_PIX_LO;
        end
        default: begin // S_PIX_LO
          fb_we_d   = 1'b1;
          fb_din_d  = {hi_q, b_din};
          fb_addr_d = FB_AW'(int'(row_q) * WIDTH + int'(col_q));
          state_d   = S_PIX_HI;
          if (col_q == col_end_q) begin
            col_d = col_start_q;
            row_d = (row_q == row_end_q) ? row_start_q : row_q + RW'(1);
          end else begin
            col_d = col_q + CW'(1);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_CMD;
      e_q          <= 1'b0;
      opc_q        <= 8'h00;
      a0_q         <= 8'h00;
      hi_q         <= 8'h00;
      rem_q        <= 2'd0;
      col_start_q  <= '0;
      col_end_q    <= CW'(WIDTH - 1);
      row_start_q  <= '0;
      row_end_q    <= RW'(HEIGHT - 1);
      col_q        <= '0;
      row_q        <= '0;
      cmd_valid_q  <= 1'b0;
      fb_we_q      <= 1'b0;
      err_q        <= 1'b0;
      display_on_q <= 1'b0;
      cmd_q        <= 8'h00;
      arg0_q       <= 8'h00;
      arg1_q       <= 8'h00;
      fb_addr_q    <= '0;
      fb_din_q     <= 16'h0000;
    end else begin
      state_q      <= state_d;
      e_q          <= b_e;
      opc_q        <= opc_d;
      a0_q         <= a0_d;
      hi_q         <= hi_d;
      rem_q        <= rem_d;
      col_start_q  <= col_start_d;
      col_end_q    <= col_end_d;
      row_start_q  <= row_start_d;
      row_end_q    <= row_end_d;
      col_q        <= col_d;
      row_q        <= row_d;
      cmd_valid_q  <= cmd_valid_d;
      fb_we_q      <= fb_we_d;
      err_q        <= err_d;
      display_on_q <= display_on_d;
      cmd_q        <= cmd_d;
      arg0_q       <= arg0_d;
      arg1_q       <= arg1_d;
      fb_addr_q    <= fb_addr_d;
      fb_din_q     <= fb_din_d;
    end
  end

  assign cmd_valid  = cmd_valid_q;
  assign cmd        = cmd_q;
  assign arg0       = arg0_q;
  assign arg1       = arg1_q;
  assign fb_we      = fb_we_q;
  assign fb_addr    = fb_addr_q;
  assign fb_din     = fb_din_q;
  assign display_on = display_on_q;
  assign err        = err_q;

endmodule

// File: tb/tb_oled_bus_responder.sv
// ---------------------------------------------------------------------------
// tb_oled_bus_responder
//   Directed test-plan steps followed by randomized bus traffic. Expected
//   responses come from a byte-level reference model that collects pending
//   command bytes in a queue and tracks the pixel cursor as plain integers.
// ---------------------------------------------------------------------------
module tb_oled_bus_responder;

`ifdef OLED_RX_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif
  localparam int W = 128;
  localparam int H = 128;

  logic        clk = 1'b0;
  logic        rst;
  logic        oled_cs, oled_e, oled_rw, oled_dc;
  logic [7:0]  oled_din;
  logic        cmd_valid, fb_we, display_on, err;
  logic [7:0]  cmd, arg0, arg1;
  logic [13:0] fb_addr;
  logic [15:0] fb_din;

  oled_bus_responder #(.WIDTH(W), .HEIGHT(H), .FB_AW(14)) dut (
    .clk(clk), .rst(rst),
    .oled_cs(oled_cs), .oled_e(oled_e), .oled_rw(oled_rw), .oled_dc(oled_dc),
    .oled_din(oled_din),
    .cmd_valid(cmd_valid), .cmd(cmd), .arg0(arg0), .arg1(arg1),
    .fb_we(fb_we), .fb_addr(fb_addr), .fb_din(fb_din),
    .display_on(display_on), .err(err)
  );

  // clock
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // ---------------- reference model ----------------
  logic [7:0] pend[$];      // opcode followed by arguments received so far
  bit         ram_mode;
  bit         have_hi;
  logic [7:0] m_hi;
  int         cx, cy, wcs, wce, wrs, wre;
  logic       e_cv, e_we, e_err, e_disp;
  logic [7:0] e_cmd, e_a0, e_a1;
  logic [13:0] e_addr;
  logic [15:0] e_din;

  function automatic int m_arity(logic [7:0] op);
    if (op inside {8'h15, 8'h75, 8'hA0, 8'hB4, 8'hD1}) return 2;
    if (op inside {8'hAE, 8'hAF, 8'h5C}) return 0;
    return 1;
  endfunction

  function automatic int clampi(int v, int lim);
    return (v > lim) ? lim : v;
  endfunction

  task automatic m_reset();
    pend.delete();
    ram_mode = 0; have_hi = 0; m_hi = 0;
    cx = 0; cy = 0; wcs = 0; wce = W - 1; wrs = 0; wre = H - 1;
    e_cv = 0; e_we = 0; e_err = 0; e_disp = 0;
    e_cmd = 0; e_a0 = 0; e_a1 = 0; e_addr = 0; e_din = 0;
  endtask

  task automatic m_event(logic [7:0] op, logic [7:0] a, logic [7:0] b);
    e_cv = 1; e_cmd = op; e_a0 = a; e_a1 = b;
  endtask

  task automatic m_byte(bit dc, logic [7:0] b);
    int lo, hi;
    e_cv = 0; e_we = 0; e_err = 0;
    if (!dc) begin
      if (pend.size() > 0 || have_hi) e_err = 1;
      pend.delete();
      have_hi  = 0;
      ram_mode = 0;
      if (m_arity(b) == 0) begin
        m_event(b, 8'h00, 8'h00);
        if (b == 8'hAF) e_disp = 1;
        if (b == 8'hAE) e_disp = 0;
        if (b == 8'h5C) begin cx = wcs; cy = wrs; ram_mode = 1; end
      end else begin
        pend.push_back(b);
      end
    end else if (pend.size() > 0) begin
      pend.push_back(b);
      if (pend.size() == m_arity(pend[0]) + 1) begin
        m_event(pend[0], pend[1], (pend.size() > 2) ? pend[2] : 8'h00);
        if (pend[0] == 8'h15 || pend[0] == 8'h75) begin
          lo = clampi(int'(pend[1]), ((pend[0] == 8'h15) ? W : H) - 1);
          hi = clampi(int'(pend[2]), ((pend[0] == 8'h15) ? W : H) - 1);
          if (hi < lo) hi = lo;
          if (pend[0] == 8'h15) begin wcs = lo; wce = hi; end
          else                  begin wrs = lo; wre = hi; end
        end
        pend.delete();
      end
    end else if (ram_mode) begin
      if (!have_hi) begin
        m_hi = b; have_hi = 1;
      end else begin
        e_we = 1; e_din = {m_hi, b}; e_addr = 14'(cy * W + cx);
        have_hi = 0;
        if (cx == wce) begin
          cx = wcs;
          cy = (cy == wre) ? wrs : cy + 1;
        end else begin
          cx = cx + 1;
        end
      end
    end else begin
      e_err = 1;
    end
  endtask

  // ---------------- checking ----------------
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outputs();
    chk("cmd_valid", 32'(cmd_valid), 32'(e_cv));
    chk("err", 32'(err), 32'(e_err));
    chk("fb_we", 32'(fb_we), 32'(e_we));
    chk("display_on", 32'(display_on), 32'(e_disp));
    chk("cmd", 32'(cmd), 32'(e_cmd));
    chk("arg0", 32'(arg0), 32'(e_a0));
    chk("arg1", 32'(arg1), 32'(e_a1));
    if (e_we) begin
      chk("fb_addr", 32'(fb_addr), 32'(e_addr));
      chk("fb_din", 32'(fb_din), 32'(e_din));
    end
  endtask

  // ---------------- driver ----------------
  // One bus cycle: raise e with the byte, drop it, wait the response
  // latency, check the response, then check that pulses last one cycle.
  task automatic send(bit cs, bit rw, bit dc, logic [7:0] b);
    @(negedge clk);
    oled_cs = cs; oled_rw = rw; oled_dc = dc; oled_din = b; oled_e = 1'b1;
    @(negedge clk);
    oled_e = 1'b0;
    if (!cs && !rw) m_byte(dc, b);
    else begin e_cv = 0; e_we = 0; e_err = 0; end
    repeat (LAT) @(negedge clk);
    chk_outputs();
    @(negedge clk);
    chk("cmd_valid_pulse", 32'(cmd_valid), 32'd0);
    chk("fb_we_pulse", 32'(fb_we), 32'd0);
    chk("err_pulse", 32'(err), 32'd0);
    oled_cs = 1'b1; oled_rw = 1'b0;
  endtask

  task automatic cmd_b(logic [7:0] b);  send(1'b0, 1'b0, 1'b0, b); endtask
  task automatic data_b(logic [7:0] b); send(1'b0, 1'b0, 1'b1, b); endtask

  logic [7:0] cmd_tab [10] = '{8'h15, 8'h75, 8'hA0, 8'hB4, 8'hD1,
                                8'hAE, 8'hAF, 8'h5C, 8'h81, 8'hA4};

  initial begin
    rst = 1'b1;
    oled_cs = 1'b1; oled_e = 1'b0; oled_rw = 1'b0; oled_dc = 1'b0; oled_din = 8'h00;
    m_reset();
    repeat (3) @(negedge clk);
    chk_outputs();
    chk("rst_fb_addr", 32'(fb_addr), 32'd0);
    chk("rst_fb_din", 32'(fb_din), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // display on/off
    cmd_b(8'hAF);
    cmd_b(8'hAE);
    // two-argument command
    cmd_b(8'hA0); data_b(8'h74); data_b(8'h00);
    // window and four pixels, then wrap
    cmd_b(8'h15); data_b(8'h10); data_b(8'h11);
    cmd_b(8'h75); data_b(8'h20); data_b(8'h21);
    cmd_b(8'h5C);
    data_b(8'h12); data_b(8'h34);
    chk("first_pixel_addr", 32'(fb_addr), 32'h1010);
    data_b(8'h56); data_b(8'h78);
    data_b(8'h9A); data_b(8'hBC);
    data_b(8'hDE); data_b(8'hF0);
    data_b(8'hFF); data_b(8'hFF);
    chk("wrap_pixel_addr", 32'(fb_addr), 32'h1010);
    cmd_b(8'hAF);                     // leaves RAM-write without err
    // protocol errors
    data_b(8'h55);
    cmd_b(8'hB4); data_b(8'h01); cmd_b(8'hAF);

    // reset between pixel high and low byte
    cmd_b(8'h5C); data_b(8'hAB);
    @(negedge clk);
    oled_cs = 1'b0; oled_rw = 1'b0; oled_dc = 1'b1; oled_din = 8'hCD; oled_e = 1'b1;
    @(negedge clk);
    rst = 1'b1; oled_e = 1'b0;
    repeat (LAT + 1) begin
      @(negedge clk);
      chk("rst_no_fb_we", 32'(fb_we), 32'd0);
    end
    oled_cs = 1'b1;
    rst = 1'b0;
    m_reset();
    @(negedge clk);
    chk_outputs();
    cmd_b(8'h5C); data_b(8'h12); data_b(8'h34);
    chk("post_rst_addr", 32'(fb_addr), 32'd0);
    // ignored strobes
    send(1'b1, 1'b0, 1'b0, 8'hAF);
    send(1'b0, 1'b1, 1'b0, 8'hAF);
    send(1'b0, 1'b1, 1'b1, 8'h77);

    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      int r;
      r = int'($urandom_range(0, 19));
      if (r == 0)      send(1'b1, 1'b0, 1'($urandom_range(0, 1)), 8'($urandom));
      else if (r == 1) send(1'b0, 1'b1, 1'($urandom_range(0, 1)), 8'($urandom));
      else if (r < 8)  cmd_b(cmd_tab[$urandom_range(0, 9)]);
      else             data_b(8'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/oled_bus_responder.md
Name: oled_bus_responder

Overview:
- Responder end of the 6800-style OLED parallel bus (cs/e/rw/dc/8-bit data) driven by the team's OLED controller.
- Decodes the command/argument byte stream and reports each complete command as a one-cycle event.
- Tracks the column/row address window and turns RAM-write pixel data into framebuffer writes.
- Serves as an on-chip display model for simulation and loopback, and as the write side of the planned framebuffer RAM.

Parameters:
- WIDTH, 128, display columns; column counters are $clog2(WIDTH) bits.
- HEIGHT, 128, display rows; row counters are $clog2(HEIGHT) bits.
- FB_AW, 14, framebuffer address width; must be at least $clog2(WIDTH*HEIGHT).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- oled_cs  in  1  chip select, active low
- oled_e  in  1  enable strobe; byte latched on its falling edge
- oled_rw  in  1  0=write, 1=read (reads ignored)
- oled_dc  in  1  0=command byte, 1=data byte
- oled_din  in  8  bus data
- cmd_valid  out  1  one-cycle pulse: command complete
- cmd  out  8  opcode of the reported command
- arg0  out  8  first argument (0 if none)
- arg1  out  8  second argument (0 if none)
- fb_we  out  1  one-cycle framebuffer write strobe
- fb_addr  out  FB_AW  row*WIDTH + col
- fb_din  out  16  RGB565 pixel, high byte first on the bus
- display_on  out  1  set by 0xAF, cleared by 0xAE
- err  out  1  one-cycle protocol-error pulse

Behaviour:
- Bus inputs are synchronous to clk.
- Strobe: e_q (oled_e registered) =1 and oled_e=0 and oled_cs=0 and oled_rw=0. The byte and dc are sampled in the strobe cycle.
- Strobes with cs=1 or rw=1 are ignored. A cs rise does not change decoder state.
- All outputs are registered; each response appears the cycle after the strobe.
- Reset values:
  - outputs: all 0.
  - e_q: 0.
  - window: col_start=0, col_end=WIDTH-1, row_start=0, row_end=HEIGHT-1.
  - cursor: 0,0.
  - state: CMD.
- Arity:
  - 0x15, 0x75, 0xA0, 0xB4, 0xD1 take 2 arguments.
  - 0xAE, 0xAF, 0x5C take 0 arguments.
  - All other opcodes take 1 argument.
- State CMD:
  - Command byte, arity 0: cmd_valid pulses with args 0. 0xAF/0xAE also update display_on. 0x5C sets the cursor to (col_start, row_start) and moves to PIX_HI.
  - Command byte, arity >0: latch opcode, set remaining=arity, move to ARGS.
  - Data byte: err pulse, byte dropped.
- State ARGS:
  - Data byte: stored into arg0 then arg1, remaining decrements.
  - At remaining=0: cmd_valid pulses in the cycle after the last argument strobe, then return to CMD.
  - On 0x15 completion: col_start=min(arg0,WIDTH-1), col_end=max(min(arg1,WIDTH-1), col_start).
  - On 0x75 completion: same rule for rows.
  - Command byte: err pulse, partial command discarded, byte decoded as a new command per CMD rules in the same cycle.
- State PIX_HI:
  - Data byte: latch high byte, move to PIX_LO.
  - Command byte: leave RAM-write mode, decode as in CMD, no err.
- State PIX_LO:
  - Data byte: fb_we pulses with fb_din={hi,lo} and fb_addr=row*WIDTH+col, then return to PIX_HI.
  - Cursor advance after the write: if col==col_end then col=col_start and the row advances, else col+1. Row advance: if row==row_end then row=row_start, else row+1 (full window wrap).
  - Command byte: err pulse (half pixel dropped), then decode as in CMD.
- Window changes while in PIX_* take effect at the next 0x5C only; the cursor is unchanged.
- cmd/arg0/arg1 hold their last values between pulses.
- cmd_valid and fb_we are never asserted in the same cycle.
- Reset mid-command or mid-pixel: all state returns to reset values, partial data is discarded, no pulses.

Optional Feature:
- OLED_RX_SYNC_EN defined: oled_cs, oled_e, oled_rw, oled_dc and oled_din pass through a 2-flop synchronizer (reset to cs=1, e=0, others 0) before edge detection. This allows a truly asynchronous external bus and adds exactly 2 cycles of latency to every response.
- Not defined: inputs are used directly, 1-cycle response latency.

Test Plan:
- Reset, then cmd 0xAF -> display_on=1 and cmd_valid pulse with cmd=0xAF, args 0. Then 0xAE -> display_on=0.
- cmd 0xA0, data 0x74, data 0x00 -> a single cmd_valid pulse, cmd=0xA0, arg0=0x74, arg1=0x00, one cycle after the 0x00 strobe; err=0.
- 0x15 0x10 0x11, 0x75 0x20 0x21, 0x5C, then 4 pixels 0x1234, 0x5678, 0x9ABC, 0xDEF0 -> fb_addr 0x1010, 0x1011, 0x1090, 0x1091 with matching fb_din.
- Same window, 5th pixel 0xFFFF -> wraps to fb_addr 0x1010. Then cmd 0xAF mid-stream -> RAM-write mode exits with no err.
- Data byte in CMD -> err pulse. 0xB4 with one argument then cmd 0xAF -> err pulse, no 0xB4 event, 0xAF event reported.
- Assert rst between the pixel high and low bytes -> no fb_we. After release, window is full-screen and 0x5C followed by a pixel writes fb_addr 0. Strobes with cs=1 or rw=1 -> no response.
